// File: rtl/mips_datapath_pc_predict_pkg.sv
//------------------------------------------------------------------------------
// mips_datapath_pc_predict_pkg : shared types for the predicting PC datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_datapath_pc_predict_pkg;

    typedef enum logic [1:0] {
        ACT_SEQ    = 2'd0,
        ACT_BRANCH = 2'd1,
        ACT_JUMP   = 2'd2,
        ACT_JUMPR  = 2'd3
    } res_action_e;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return c[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_datapath_pc_btb.sv
//------------------------------------------------------------------------------
// mips_datapath_pc_btb : direct-mapped branch target buffer with 2-bit counters
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_datapath_pc_btb
    import mips_datapath_pc_predict_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-3:0] lookup_word,
    output logic              lookup_taken,
    output logic [ADDR_W-1:0] lookup_target,
    input  logic              train_valid,
    input  logic [1:0]        train_action,
    input  logic [ADDR_W-3:0] train_word,
    input  logic [ADDR_W-1:0] train_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        ctr_e              ctr;
        logic [ADDR_W-1:0] target;
    } btb_entry_t;

    btb_entry_t entries [BTB_DEPTH];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    btb_entry_t       lookup_entry;

    logic [IDX_W-1:0] train_idx;
    logic [TAG_W-1:0] train_tag;
    btb_entry_t       train_entry;
    logic             train_hit;
    btb_entry_t       upd_entry;
    logic             write_en;

    // Lookup reads the array directly, so a same-cycle train is not visible yet.
    assign lookup_idx    = lookup_word[IDX_W-1:0];
    assign lookup_tag    = lookup_word[ADDR_W-3:IDX_W];
    assign lookup_entry  = entries[lookup_idx];
    assign lookup_taken  = lookup_entry.valid && (lookup_entry.tag == lookup_tag)
                           && ctr_taken(lookup_entry.ctr);
    assign lookup_target = lookup_entry.target;

    assign train_idx   = train_word[IDX_W-1:0];
    assign train_tag   = train_word[ADDR_W-3:IDX_W];
    assign train_entry = entries[train_idx];
    assign train_hit   = train_entry.valid && (train_entry.tag == train_tag);

    always_comb begin
        upd_entry = train_entry;
        write_en  = 1'b0;
        if (train_valid) begin
            if (train_action != ACT_SEQ) begin
                write_en         = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = train_tag;
                upd_entry.target = train_target;
                upd_entry.ctr    = train_hit ? ctr_inc(train_entry.ctr) : WEAK_T;
                // Unconditional transfers are always taken; pin them strong.
                if (train_action == ACT_JUMP || train_action == ACT_JUMPR) begin
                    upd_entry.ctr = STRONG_T;
                end
            end else if (train_hit) begin
                write_en      = 1'b1;
                upd_entry.ctr = ctr_dec(train_entry.ctr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (write_en) begin
            entries[train_idx] <= upd_entry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_datapath_pc_predict.sv
//------------------------------------------------------------------------------
// mips_datapath_pc_predict : fetch PC register with BTB next-address prediction
// and execute-stage resolution. BTB built only with MIPS_DATAPATH_PC_BTB_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_datapath_pc_predict
    import mips_datapath_pc_predict_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BTB_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              resValid,
    input  logic [1:0]        resAction,
    input  logic [ADDR_W-1:0] resPc,
    input  logic [15:0]       resOffset,
    input  logic [25:0]       resJump,
    input  logic [ADDR_W-1:0] resJumpr,
    input  logic              resPredTaken,
    input  logic [ADDR_W-1:0] resPredTarget,
    output logic [ADDR_W-1:0] addrCurr,
    output logic [ADDR_W-1:0] addrNext,
    output logic              predTaken,
    output logic [ADDR_W-1:0] predTarget,
    output logic              mispredict
);

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] res_seq;
    logic [ADDR_W-1:0] branch_disp;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] res_target;
    logic [ADDR_W-1:0] res_actual;
    logic              res_taken;

    assign seq_addr    = addrCurr + ADDR_W'(4);
    assign res_seq     = resPc + ADDR_W'(4);
    assign branch_disp = {{(ADDR_W-18){resOffset[15]}}, resOffset, 2'b00};

    // With a 28-bit address space the jump field covers the whole range.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_target = {res_seq[ADDR_W-1:28], resJump, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {resJump, 2'b00};
        end
    endgenerate

    always_comb begin
        res_target = res_seq;
        case (resAction)
            ACT_BRANCH: res_target = res_seq + branch_disp;
            ACT_JUMP:   res_target = jump_target;
            ACT_JUMPR:  res_target = resJumpr;
            default:    res_target = res_seq;
        endcase
    end

    assign res_taken  = (resAction != ACT_SEQ);
    assign res_actual = res_taken ? res_target : res_seq;
    assign mispredict = resValid && ((resPredTaken != res_taken)
                        || (res_taken && (resPredTarget != res_target)));

`ifdef MIPS_DATAPATH_PC_BTB_EN
    mips_datapath_pc_btb #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_word   (addrCurr[ADDR_W-1:2]),
        .lookup_taken  (predTaken),
        .lookup_target (predTarget),
        .train_valid   (resValid),
        .train_action  (resAction),
        .train_word    (resPc[ADDR_W-1:2]),
        .train_target  (res_target)
    );
`else
    assign predTaken  = 1'b0;
    assign predTarget = seq_addr;
`endif

    always_comb begin
        addrNext = seq_addr;
        if (mispredict) begin
            addrNext = res_actual;
        end else if (stall) begin
            addrNext = addrCurr;
        end else if (predTaken) begin
            addrNext = predTarget;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrCurr <= RESET_VECTOR[ADDR_W-1:0];
        end else begin
            addrCurr <= addrNext;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_datapath_pc_predict.sv
//------------------------------------------------------------------------------
// tb_mips_datapath_pc_predict : randomized and directed checks of the
// predicting PC datapath against a behavioural next-PC / BTB model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mips_datapath_pc_predict;

    localparam logic [31:0] RV = 32'h0040_0000;
`ifdef MIPS_DATAPATH_PC_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall;
    logic        resValid;
    logic [1:0]  resAction;
    logic [31:0] resPc;
    logic [15:0] resOffset;
    logic [25:0] resJump;
    logic [31:0] resJumpr;
    logic        resPredTaken;
    logic [31:0] resPredTarget;
    logic [31:0] addrCurr;
    logic [31:0] addrNext;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        mispredict;

    always #5 clk = ~clk;

    mips_datapath_pc_predict #(
        .ADDR_W       (32),
        .RESET_VECTOR (RV),
        .BTB_DEPTH    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .resValid      (resValid),
        .resAction     (resAction),
        .resPc         (resPc),
        .resOffset     (resOffset),
        .resJump       (resJump),
        .resJumpr      (resJumpr),
        .resPredTaken  (resPredTaken),
        .resPredTarget (resPredTarget),
        .addrCurr      (addrCurr),
        .addrNext      (addrNext),
        .predTaken     (predTaken),
        .predTarget    (predTarget),
        .mispredict    (mispredict)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: fetch PC plus a slot-keyed table of trained instructions.
    logic [31:0] m_pc;
    logic [31:0] ent_word [int];
    int          ent_ctr  [int];
    logic [31:0] ent_tgt  [int];

    logic        e_pt, e_mis, e_taken;
    logic [31:0] e_ptgt, e_next, e_tgt, e_actual;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s;
        s = slot(a);
        return ent_word.exists(s) && (ent_word[s] == (a >> 2));
    endfunction

    task automatic model_reset();
        m_pc = RV;
        ent_word.delete();
        ent_ctr.delete();
        ent_tgt.delete();
    endtask

    task automatic calc();
        logic [31:0] rs;
        int s;
        rs = resPc + 32'd4;
        case (resAction)
            2'd1:    e_tgt = rs + 32'(int'($signed(resOffset)) * 4);
            2'd2:    e_tgt = (rs & 32'hF000_0000) | (32'(resJump) << 2);
            2'd3:    e_tgt = resJumpr;
            default: e_tgt = rs;
        endcase
        e_taken  = (resAction != 2'd0);
        e_actual = e_taken ? e_tgt : rs;
        e_mis    = resValid && ((resPredTaken != e_taken) || (e_taken && resPredTarget != e_tgt));
        s        = slot(m_pc);
        e_pt     = 1'b0;
        e_ptgt   = m_pc + 32'd4;
        if (BTB_ON && model_hit(m_pc)) begin
            e_pt   = (ent_ctr[s] >= 2);
            e_ptgt = ent_tgt[s];
        end
        if (e_mis)       e_next = e_actual;
        else if (stall)  e_next = m_pc;
        else if (e_pt)   e_next = e_ptgt;
        else             e_next = m_pc + 32'd4;
    endtask

    task automatic commit();
        int s;
        @(posedge clk);
        if (BTB_ON && resValid) begin
            s = slot(resPc);
            if (e_taken) begin
                if (model_hit(resPc)) begin
                    ent_ctr[s] = (ent_ctr[s] < 3) ? ent_ctr[s] + 1 : 3;
                end else begin
                    ent_word[s] = resPc >> 2;
                    ent_ctr[s]  = 2;
                end
                ent_tgt[s] = e_tgt;
                if (resAction >= 2'd2) ent_ctr[s] = 3;
            end else if (model_hit(resPc)) begin
                ent_ctr[s] = (ent_ctr[s] > 0) ? ent_ctr[s] - 1 : 0;
            end
        end
        m_pc = e_next;
    endtask

    task automatic idle();
        stall         = 1'b0;
        resValid      = 1'b0;
        resAction     = 2'd0;
        resPc         = 32'd0;
        resOffset     = 16'd0;
        resJump       = 26'd0;
        resJumpr      = 32'd0;
        resPredTaken  = 1'b0;
        resPredTarget = 32'd0;
    endtask

    task automatic settle();
        #1;
        calc();
    endtask

    task automatic next_cycle();
        commit();
        @(negedge clk);
        idle();
        settle();
    endtask

    task automatic set_res(input logic [1:0] act, input logic [31:0] pc, input logic pt,
                           input logic [31:0] ptgt);
        resValid      = 1'b1;
        resAction     = act;
        resPc         = pc;
        resPredTaken  = pt;
        resPredTarget = ptgt;
    endtask

    task automatic run_to(input logic [31:0] target);
        int n;
        n = 0;
        while (m_pc != target && n < 40) begin
            next_cycle();
            n++;
        end
        total++;
        if (addrCurr !== target) begin
            bad++;
            $display("FAIL run_to addrCurr=%h required=%h", addrCurr, target);
        end
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (addrCurr !== RV || predTaken !== 1'b0 || mispredict !== 1'b0) begin
            bad++;
            $display("FAIL reset_state addrCurr=%h predTaken=%b mispredict=%b required=%h/0/0",
                     addrCurr, predTaken, mispredict, RV);
        end
        rst_n = 1'b1;
        settle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (addrCurr !== RV + 32'(4 * k) || predTaken !== 1'b0) begin
                bad++;
                $display("FAIL reset_seq k=%0d addrCurr=%h predTaken=%b required=%h/0",
                         k, addrCurr, predTaken, RV + 32'(4 * k));
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        run_to(RV + 32'h10);
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1;
            settle();
            total++;
            if (addrCurr !== RV + 32'h10 || addrNext !== RV + 32'h10) begin
                bad++;
                $display("FAIL stall_hold k=%0d addrCurr=%h addrNext=%h required=%h",
                         k, addrCurr, addrNext, RV + 32'h10);
            end
            next_cycle();
        end
        total++;
        if (addrCurr !== RV + 32'h10 || addrNext !== RV + 32'h14) begin
            bad++;
            $display("FAIL stall_release addrCurr=%h addrNext=%h required=%h/%h",
                     addrCurr, addrNext, RV + 32'h10, RV + 32'h14);
        end
        next_cycle();
        total++;
        if (addrCurr !== RV + 32'h14) begin
            bad++;
            $display("FAIL stall_resume addrCurr=%h required=%h", addrCurr, RV + 32'h14);
        end
    endtask

    task automatic test_branch();
        set_res(2'd1, 32'h0040_0020, 1'b0, 32'd0);
        resOffset = 16'hFFFC;
        settle();
        total++;
        if (mispredict !== 1'b1 || addrNext !== 32'h0040_0014) begin
            bad++;
            $display("FAIL branch_redirect mispredict=%b addrNext=%h required=1/%h",
                     mispredict, addrNext, 32'h0040_0014);
        end
        next_cycle();
        total++;
        if (addrCurr !== 32'h0040_0014) begin
            bad++;
            $display("FAIL branch_latency addrCurr=%h required=%h", addrCurr, 32'h0040_0014);
        end
        run_to(32'h0040_0020);
        total++;
        if (predTaken !== BTB_ON || predTarget !== (BTB_ON ? 32'h0040_0014 : 32'h0040_0024)) begin
            bad++;
            $display("FAIL branch_refetch predTaken=%b predTarget=%h required=%b/%h", predTaken,
                     predTarget, BTB_ON, BTB_ON ? 32'h0040_0014 : 32'h0040_0024);
        end
    endtask

    task automatic test_jump_stall();
        set_res(2'd2, 32'h04FF_FFFC, 1'b0, 32'd0);
        resJump = 26'h010_0000;
        stall   = 1'b1;
        settle();
        total++;
        if (mispredict !== 1'b1 || addrNext !== 32'h0040_0000) begin
            bad++;
            $display("FAIL jump_over_stall mispredict=%b addrNext=%h required=1/%h",
                     mispredict, addrNext, 32'h0040_0000);
        end
        next_cycle();
        total++;
        if (addrCurr !== 32'h0040_0000) begin
            bad++;
            $display("FAIL jump_latency addrCurr=%h required=%h", addrCurr, 32'h0040_0000);
        end
    endtask

    task automatic test_alias();
        set_res(2'd1, 32'h0040_0060, 1'b0, 32'd0);
        resOffset = 16'h0010;
        settle();
        total++;
        if (mispredict !== 1'b1 || addrNext !== 32'h0040_00A4) begin
            bad++;
            $display("FAIL alias_branch mispredict=%b addrNext=%h required=1/%h",
                     mispredict, addrNext, 32'h0040_00A4);
        end
        next_cycle();
        set_res(2'd3, 32'h0040_0100, 1'b0, 32'd0);
        resJumpr = 32'h0040_0020;
        settle();
        total++;
        if (addrNext !== 32'h0040_0020) begin
            bad++;
            $display("FAIL alias_jumpr addrNext=%h required=%h", addrNext, 32'h0040_0020);
        end
        next_cycle();
        total++;
        if (addrCurr !== 32'h0040_0020 || predTaken !== 1'b0 || addrNext !== 32'h0040_0024) begin
            bad++;
            $display("FAIL alias_evict addrCurr=%h predTaken=%b addrNext=%h required=%h/0/%h",
                     addrCurr, predTaken, addrNext, 32'h0040_0020, 32'h0040_0024);
        end
    endtask

    task automatic test_wrap();
        set_res(2'd3, 32'h0040_0100, 1'b1, 32'h0040_0104);
        resJumpr = 32'hFFFF_FFFC;
        settle();
        total++;
        if (mispredict !== 1'b1 || addrNext !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrong_target mispredict=%b addrNext=%h required=1/%h",
                     mispredict, addrNext, 32'hFFFF_FFFC);
        end
        next_cycle();
        set_res(2'd3, 32'h0040_0100, 1'b1, 32'hFFFF_FFFC);
        resJumpr = 32'hFFFF_FFFC;
        settle();
        total++;
        if (mispredict !== 1'b0 || addrNext !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_seq mispredict=%b addrNext=%h required=0/00000000",
                     mispredict, addrNext);
        end
        next_cycle();
        total++;
        if (addrCurr !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_addr addrCurr=%h required=00000000", addrCurr);
        end
    endtask

    task automatic test_reset_mid();
        set_res(2'd1, 32'h0040_0040, 1'b0, 32'd0);
        resOffset = 16'h0004;
        #1;
        rst_n = 1'b0;
        #1;
        idle();
        #1;
        total++;
        if (addrCurr !== RV || predTaken !== 1'b0 || mispredict !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid addrCurr=%h predTaken=%b mispredict=%b required=%h/0/0",
                     addrCurr, predTaken, mispredict, RV);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        settle();
        run_to(32'h0040_0060);
        total++;
        if (predTaken !== 1'b0) begin
            bad++;
            $display("FAIL reset_clears_btb predTaken=%b required=0", predTaken);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            stall        = ($urandom_range(0, 4) == 0);
            resValid     = 1'($urandom_range(0, 1));
            resAction    = 2'($urandom_range(0, 3));
            resPc        = RV + 32'(4 * $urandom_range(0, 23));
            resOffset    = 16'($urandom_range(0, 31)) - 16'd16;
            resJump      = 26'((RV >> 2) + $urandom_range(0, 23));
            resJumpr     = RV + 32'(4 * $urandom_range(0, 23));
            resPredTaken = 1'($urandom_range(0, 1));
            calc();
            resPredTarget = ($urandom_range(0, 2) != 0) ? e_tgt : RV + 32'(4 * $urandom_range(0, 23));
            settle();
            total++;
            if (addrCurr !== m_pc) begin
                bad++;
                $display("FAIL rand_addrCurr k=%0d got=%h required=%h", k, addrCurr, m_pc);
            end
            total++;
            if (mispredict !== e_mis) begin
                bad++;
                $display("FAIL rand_mispredict k=%0d got=%b required=%b", k, mispredict, e_mis);
            end
            total++;
            if (predTaken !== e_pt) begin
                bad++;
                $display("FAIL rand_predTaken k=%0d pc=%h got=%b required=%b", k, m_pc, predTaken, e_pt);
            end
            if (e_pt || !BTB_ON) begin
                total++;
                if (predTarget !== e_ptgt) begin
                    bad++;
                    $display("FAIL rand_predTarget k=%0d got=%h required=%h", k, predTarget, e_ptgt);
                end
            end
            total++;
            if (addrNext !== e_next) begin
                bad++;
                $display("FAIL rand_addrNext k=%0d got=%h required=%h", k, addrNext, e_next);
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_jump_stall();
        test_alias();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
